rf_writeback_ctrl: RTL and testbench
====================================

Name: rf_writeback_ctrl

Overview:
- Producer side of the register file write port. Merges single-cycle pipeline writebacks with writebacks from a long-latency unit (load/mul/div) into one registered RF write port.
- Buffers long-latency results in a small FIFO.
- Holds a per-register scoreboard so decode can stall on operands whose writes are still pending.
- Sits between execute/memory and the register file; drives the RF's wen/waddr/wdata.

Parameters:
- DEPTH, 2: secondary FIFO entries; power of two, minimum 2.

Ports:
- i_clk  in  1  global clock
- i_rst  in  1  synchronous active-high reset
- i_issue_valid  in  1  decode issuing a long-latency op
- i_issue_rd  in  5  destination of the issued long-latency op
- o_issue_ready  out  1  issue accepted this cycle
- i_rs1_raddr  in  5  decode operand 1 address
- o_rs1_pending  out  1  operand 1 has an outstanding long-latency write
- i_rs2_raddr  in  5  decode operand 2 address
- o_rs2_pending  out  1  operand 2 has an outstanding long-latency write
- i_pri_wen  in  1  pipeline writeback enable; no backpressure
- i_pri_waddr  in  5  pipeline writeback address
- i_pri_wdata  in  32  pipeline writeback data
- i_sec_valid  in  1  long-latency result valid
- o_sec_ready  out  1  FIFO can accept
- i_sec_waddr  in  5  long-latency result address
- i_sec_wdata  in  32  long-latency result data
- o_rd_wen  out  1  RF write enable (registered)
- o_rd_waddr  out  5  RF write address (registered)
- o_rd_wdata  out  32  RF write data (registered)

Behaviour:
- Reset (synchronous, i_rst high at posedge):
  - pending bits all 0, FIFO empty.
  - o_rd_wen=0, o_rd_waddr=0, o_rd_wdata=0.
  - Anything in flight (FIFO contents, pending bits) is discarded.
- Primary valid: pri_act = i_pri_wen && i_pri_waddr!=0. A write to x0 is a no-op.
- Output register, updated every cycle:
  - If pri_act: load primary write, o_rd_wen=1. Primary always wins.
  - Else if FIFO non-empty: pop head, load it, o_rd_wen=1, mark source=secondary.
  - Else: o_rd_wen=0; waddr/wdata hold their previous value.
  - Latency is exactly 1 cycle from the input or FIFO head to o_rd_*.
- Secondary handshake:
  - o_sec_ready = !full, combinational from the FIFO count only.
  - Transfer occurs when i_sec_valid && o_sec_ready.
  - A transfer with i_sec_waddr==0 completes the handshake but is not enqueued.
  - Push and pop in the same cycle is allowed at any occupancy. When full, pop frees the slot only on the next cycle; ready stays low this cycle.
  - Pointers wrap modulo DEPTH; occupancy count is $clog2(DEPTH)+1 bits.
- Scoreboard: pending[31:0], with pending[0] always 0.
  - o_issue_ready = (i_issue_rd==0) || !pending[i_issue_rd]. This is the WAW stall.
  - On i_issue_valid && o_issue_ready && rd!=0: set pending[rd] at the edge.
  - Clear pending[a] at the edge where o_rd_wen=1 with source secondary and o_rd_waddr==a, i.e. the same edge the RF commits the data.
  - Set and clear on the same index in the same cycle: set wins. This cannot legally happen because issue_ready is low while pending.
- o_rsN_pending = pending[i_rsN_raddr], combinational. Address 0 always returns 0.
- A primary write to a pending register is a pipeline error. It is written normally; pending is unaffected.
- Starvation: secondary drains only in cycles with !pri_act. This is accepted by design.

Optional Feature:
- Macro: RF_WB_STATS_EN
- Defined:
  - Adds output o_stall_cnt [31:0].
  - Increments (wrapping) each cycle FIFO is non-empty and pri_act blocks the pop.
  - Increments each cycle i_sec_valid && !o_sec_ready.
  - If both conditions hold in the same cycle, increments by 2.
  - Reset to 0.
- Undefined: the port and counter do not exist; behaviour is otherwise identical.

Test Plan:
- Reset then idle -> o_rd_wen=0, o_rd_waddr=0, o_rd_wdata=0, o_sec_ready=1, all pending=0.
- Pri write x5=0xDEADBEEF in cycle N -> cycle N+1: o_rd_wen=1, waddr=5, wdata=0xDEADBEEF. Pri write to x0 -> o_rd_wen=0.
- Issue rd=7; same-cycle query rs1=7 -> pending=0. Next cycle -> pending=1 and issue rd=7 gives ready=0. Sec result x7=0x1234 with pri idle -> o_rd_* shows x7 one cycle later; pending[7] clears at the next edge.
- Pri active 4 consecutive cycles while sec pushes 3 results (DEPTH=2) -> ready drops after 2 pushes. Pri data appears in order; the 2 queued entries drain FIFO-order in the 2 cycles after pri goes idle.
- Sec push with waddr=0 -> handshake completes; FIFO count is unchanged and no RF write occurs.
- Reset asserted with FIFO full and pending[3] set -> next cycle FIFO empty, pending all 0, o_rd_wen=0. With RF_WB_STATS_EN, o_stall_cnt=0.

Source files
------------

// File: rtl/rf_writeback_ctrl.sv
// rf_writeback_ctrl: merges pipeline writebacks and long-latency results into
// one registered register-file write port, and keeps a per-register pending
// scoreboard so that decode can stall on outstanding long-latency writes.
// Optional build macro: RF_WB_STATS_EN adds the o_stall_cnt output counter.
module rf_writeback_ctrl #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_issue_valid,
  input  logic [4:0]  i_issue_rd,
  output logic        o_issue_ready,
  input  logic [4:0]  i_rs1_raddr,
  output logic        o_rs1_pending,
  input  logic [4:0]  i_rs2_raddr,
  output logic        o_rs2_pending,
  input  logic        i_pri_wen,
  input  logic [4:0]  i_pri_waddr,
  input  logic [31:0] i_pri_wdata,
  input  logic        i_sec_valid,
  output logic        o_sec_ready,
  input  logic [4:0]  i_sec_waddr,
  input  logic [31:0] i_sec_wdata,
  output logic        o_rd_wen,
  output logic [4:0]  o_rd_waddr,
  output logic [31:0] o_rd_wdata
`ifdef RF_WB_STATS_EN
  ,
  output logic [31:0] o_stall_cnt
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [4:0]    fifo_addr [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          pri_act;
  logic          sec_push;
  logic          sec_pop;
  logic          rd_src_sec;
  logic          issue_set;
  logic [31:0]   pending;
  logic [31:0]   pending_nxt;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign pri_act   = i_pri_wen && (i_pri_waddr != 5'd0);
  assign sec_push  = i_sec_valid && !full && (i_sec_waddr != 5'd0);
  assign sec_pop   = !pri_act && !empty;
  assign issue_set = i_issue_valid && o_issue_ready && (i_issue_rd != 5'd0);

  assign o_sec_ready   = !full;
  assign o_issue_ready = (i_issue_rd == 5'd0) || !pending[i_issue_rd];
  assign o_rs1_pending = pending[i_rs1_raddr];
  assign o_rs2_pending = pending[i_rs2_raddr];

  // FIFO storage; contents need no reset since occupancy gates every read
  always_ff @(posedge i_clk) begin
    if (sec_push) begin
      fifo_addr[wr_ptr] <= i_sec_waddr;
      fifo_data[wr_ptr] <= i_sec_wdata;
    end
  end

  // FIFO pointers and occupancy; a pop frees its slot only from the next cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (sec_push) wr_ptr <= wr_ptr + AW'(1);
      if (sec_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(sec_push) - CW'(sec_pop);
    end
  end

  // Registered write port: primary always wins, FIFO head drains when idle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rd_wen   <= 1'b0;
      o_rd_waddr <= 5'd0;
      o_rd_wdata <= 32'd0;
      rd_src_sec <= 1'b0;
    end else if (pri_act) begin
      o_rd_wen   <= 1'b1;
      o_rd_waddr <= i_pri_waddr;
      o_rd_wdata <= i_pri_wdata;
      rd_src_sec <= 1'b0;
    end else if (!empty) begin
      o_rd_wen   <= 1'b1;
      o_rd_waddr <= fifo_addr[rd_ptr];
      o_rd_wdata <= fifo_data[rd_ptr];
      rd_src_sec <= 1'b1;
    end else begin
      o_rd_wen   <= 1'b0;
      rd_src_sec <= 1'b0;
    end
  end

  // Scoreboard next state: clear on secondary commit, set on issue (set wins)
  always_comb begin
    pending_nxt = pending;
    if (o_rd_wen && rd_src_sec) pending_nxt[o_rd_waddr] = 1'b0;
    if (issue_set) pending_nxt[i_issue_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge i_clk) begin
    if (i_rst) pending <= '0;
    else       pending <= pending_nxt;
  end

`ifdef RF_WB_STATS_EN
  logic [1:0] stall_inc;

  assign stall_inc = {1'b0, pri_act && !empty} + {1'b0, i_sec_valid && full};

  // Wrapping count of blocked pops plus refused secondary offers
  always_ff @(posedge i_clk) begin
    if (i_rst) o_stall_cnt <= 32'd0;
    else       o_stall_cnt <= o_stall_cnt + 32'(stall_inc);
  end
`endif

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Self-checking bench for rf_writeback_ctrl: directed scenarios followed by a
// random phase, with expected RF writes queued on the scoreboard as stimulus
// is driven and popped when the write port produces them.
module tb_rf_writeback_ctrl;

  localparam int unsigned DEPTH = 2;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_issue_valid;
  logic [4:0]  i_issue_rd;
  logic        o_issue_ready;
  logic [4:0]  i_rs1_raddr;
  logic        o_rs1_pending;
  logic [4:0]  i_rs2_raddr;
  logic        o_rs2_pending;
  logic        i_pri_wen;
  logic [4:0]  i_pri_waddr;
  logic [31:0] i_pri_wdata;
  logic        i_sec_valid;
  logic        o_sec_ready;
  logic [4:0]  i_sec_waddr;
  logic [31:0] i_sec_wdata;
  logic        o_rd_wen;
  logic [4:0]  o_rd_waddr;
  logic [31:0] o_rd_wdata;
`ifdef RF_WB_STATS_EN
  logic [31:0] o_stall_cnt;
`endif

  rf_writeback_ctrl #(.DEPTH(DEPTH)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_issue_valid (i_issue_valid),
    .i_issue_rd    (i_issue_rd),
    .o_issue_ready (o_issue_ready),
    .i_rs1_raddr   (i_rs1_raddr),
    .o_rs1_pending (o_rs1_pending),
    .i_rs2_raddr   (i_rs2_raddr),
    .o_rs2_pending (o_rs2_pending),
    .i_pri_wen     (i_pri_wen),
    .i_pri_waddr   (i_pri_waddr),
    .i_pri_wdata   (i_pri_wdata),
    .i_sec_valid   (i_sec_valid),
    .o_sec_ready   (o_sec_ready),
    .i_sec_waddr   (i_sec_waddr),
    .i_sec_wdata   (i_sec_wdata),
    .o_rd_wen      (o_rd_wen),
    .o_rd_waddr    (o_rd_waddr),
    .o_rd_wdata    (o_rd_wdata)
`ifdef RF_WB_STATS_EN
    ,
    .o_stall_cnt   (o_stall_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  int          total = 0;
  int          bad   = 0;
  wr_t         mq[$];
  wr_t         sb[$];
  logic [31:0] pend      = '0;
  logic        last_sec  = 1'b0;
  logic [4:0]  last_addr = '0;
  logic        exp_wen   = 1'b0;
  logic [4:0]  hold_addr = '0;
  logic [31:0] hold_data = '0;
  logic [31:0] exp_stall = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    i_rst = 1'b0; i_issue_valid = 1'b0; i_issue_rd = '0;
    i_rs1_raddr = '0; i_rs2_raddr = '0;
    i_pri_wen = 1'b0; i_pri_waddr = '0; i_pri_wdata = '0;
    i_sec_valid = 1'b0; i_sec_waddr = '0; i_sec_wdata = '0;
  endtask

  // One clock: check combinational outputs, advance the model, check registers
  task automatic cycle();
    logic        pri;
    logic        full;
    logic        iss_rdy;
    logic [31:0] np;
    wr_t         w;
    #1;
    full    = (mq.size() >= DEPTH);
    iss_rdy = (i_issue_rd == 5'd0) || !pend[i_issue_rd];
    check("sec_ready",   32'(o_sec_ready),   32'(!full));
    check("issue_ready", 32'(o_issue_ready), 32'(iss_rdy));
    check("rs1_pending", 32'(o_rs1_pending), 32'(pend[i_rs1_raddr]));
    check("rs2_pending", 32'(o_rs2_pending), 32'(pend[i_rs2_raddr]));
    pri = i_pri_wen && (i_pri_waddr != 5'd0);
    if (i_rst) begin
      mq.delete(); sb.delete();
      pend = '0; last_sec = 1'b0; exp_wen = 1'b0;
      hold_addr = '0; hold_data = '0; exp_stall = '0;
    end else begin
      exp_stall = exp_stall + 32'(mq.size() > 0 && pri) + 32'(i_sec_valid && full);
      np = pend;
      if (last_sec) np[last_addr] = 1'b0;
      if (i_issue_valid && iss_rdy && i_issue_rd != 5'd0) np[i_issue_rd] = 1'b1;
      last_sec = 1'b0;
      if (pri) begin
        w.a = i_pri_waddr; w.d = i_pri_wdata;
        sb.push_back(w); exp_wen = 1'b1;
      end else if (mq.size() > 0) begin
        w = mq.pop_front();
        sb.push_back(w); exp_wen = 1'b1;
        last_sec = 1'b1; last_addr = w.a;
      end else begin
        exp_wen = 1'b0;
      end
      if (i_sec_valid && !full && i_sec_waddr != 5'd0) begin
        w.a = i_sec_waddr; w.d = i_sec_wdata;
        mq.push_back(w);
      end
      pend = np;
    end
    @(posedge i_clk);
    #1;
    check("rd_wen", 32'(o_rd_wen), 32'(exp_wen));
    if (exp_wen && sb.size() > 0) begin
      w = sb.pop_front();
      hold_addr = w.a; hold_data = w.d;
    end
    check("rd_waddr", 32'(o_rd_waddr), 32'(hold_addr));
    check("rd_wdata", o_rd_wdata, hold_data);
`ifdef RF_WB_STATS_EN
    check("stall_cnt", o_stall_cnt, exp_stall);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    i_rst = 1'b1;
    cycle(); cycle();
    idle();
    cycle(); cycle();

    // Primary write, then a write to x0 that must be dropped
    i_pri_wen = 1'b1; i_pri_waddr = 5'd5; i_pri_wdata = 32'hDEADBEEF;
    cycle();
    i_pri_waddr = 5'd0; i_pri_wdata = 32'h11111111;
    cycle();
    idle(); cycle();

    // Issue x7, observe pending and WAW stall, then complete it via secondary
    i_issue_valid = 1'b1; i_issue_rd = 5'd7; i_rs1_raddr = 5'd7;
    cycle();
    cycle();
    idle(); i_rs1_raddr = 5'd7; i_rs2_raddr = 5'd7;
    i_sec_valid = 1'b1; i_sec_waddr = 5'd7; i_sec_wdata = 32'h1234;
    cycle();
    i_sec_valid = 1'b0;
    for (int i = 0; i < 4; i++) cycle();

    // Primary busy 4 cycles while secondary offers 3 results
    for (int i = 0; i < 4; i++) begin
      idle();
      i_pri_wen = 1'b1; i_pri_waddr = 5'(10 + i); i_pri_wdata = 32'hA000 + 32'(i);
      if (i < 3) begin
        i_sec_valid = 1'b1; i_sec_waddr = 5'(20 + i); i_sec_wdata = 32'hB000 + 32'(i);
      end
      cycle();
    end
    idle();
    for (int i = 0; i < 3; i++) cycle();

    // Secondary offer to x0: accepted, never written
    i_sec_valid = 1'b1; i_sec_waddr = 5'd0; i_sec_wdata = 32'hCAFE;
    cycle();
    idle(); cycle(); cycle();

    // Reset while FIFO full and x3 pending
    i_issue_valid = 1'b1; i_issue_rd = 5'd3;
    cycle();
    for (int i = 0; i < 3; i++) begin
      idle(); i_rs1_raddr = 5'd3;
      i_pri_wen = 1'b1; i_pri_waddr = 5'd9; i_pri_wdata = 32'(i);
      i_sec_valid = 1'b1; i_sec_waddr = 5'(4 + i); i_sec_wdata = 32'h5000 + 32'(i);
      cycle();
    end
    idle(); i_rst = 1'b1; i_rs1_raddr = 5'd3;
    cycle();
    idle(); i_rs1_raddr = 5'd3;
    cycle(); cycle();

    // Random traffic over a small register range to provoke hazards
    for (int i = 0; i < 400; i++) begin
      idle();
      i_issue_valid = 1'($urandom_range(0, 1));
      i_issue_rd    = 5'($urandom_range(0, 7));
      i_rs1_raddr   = 5'($urandom_range(0, 7));
      i_rs2_raddr   = 5'($urandom_range(0, 7));
      i_pri_wen     = ($urandom_range(0, 2) == 0);
      i_pri_waddr   = 5'($urandom_range(0, 7));
      i_pri_wdata   = $urandom;
      i_sec_valid   = 1'($urandom_range(0, 1));
      i_sec_waddr   = 5'($urandom_range(0, 7));
      i_sec_wdata   = $urandom;
      cycle();
    end
    idle();
    for (int i = 0; i < 4; i++) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
